vigna_prefetch: RTL and testbench



---
 rtl/vigna_prefetch_pkg.sv | 11 +
 rtl/vigna_prefetch_if.sv | 17 +
 rtl/vigna_sync_fifo.sv | 50 +++++
 rtl/vigna_prefetch.sv | 96 +++++++++
 tb/tb_vigna_prefetch.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/vigna_prefetch_pkg.sv
// Shared constants for the vigna instruction prefetch unit.
//   VIGNA_ILEN            : instruction word width
//   VIGNA_XLEN            : default instruction address width
//   VIGNA_INST_BYTES      : fetch stride in bytes
//   VIGNA_CORE_RESET_ADDR : first fetch address after reset
package vigna_prefetch_pkg;
   localparam int          VIGNA_ILEN            = 32;
   localparam int          VIGNA_XLEN            = 32;
   localparam int          VIGNA_INST_BYTES      = 4;
   localparam logic [31:0] VIGNA_CORE_RESET_ADDR = 32'h0000_0100;
endpackage

// File: rtl/vigna_prefetch_if.sv
// Instruction bus between the prefetch unit (master) and memory (slave).
// Single outstanding request; the response arrives in the cycle i_ready=1.
//   i_valid : request valid, held until i_ready
//   i_addr  : word-aligned fetch address
//   i_ready : response strobe, i_rdata valid in the same cycle
//   i_rdata : fetched instruction
interface vigna_prefetch_if #(
   parameter int ADDR_WIDTH = 32
) ();
   logic                  i_valid;
   logic                  i_ready;
   logic [ADDR_WIDTH-1:0] i_addr;
   logic [31:0]           i_rdata;

   modport master (output i_valid, output i_addr, input i_ready, input i_rdata);
   modport slave  (input i_valid, input i_addr, output i_ready, output i_rdata);
endinterface

// File: rtl/vigna_sync_fifo.sv
// Registered synchronous FIFO. flush wins over push and pop.
//   clk/resetn : clock, async active-low reset
//   push/pop   : write din / advance head (caller guarantees not full / not empty)
//   flush      : empty the queue
//   dout       : head entry (from storage)
//   count      : entries held
module vigna_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else if (flush) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_q + PW'(push);
         rd_q  <= rd_q + PW'(pop);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_q] <= din;
   end

   assign dout  = mem_q[rd_q];
   assign count = cnt_q;
endmodule

// File: rtl/vigna_prefetch.sv
// Instruction prefetch unit: issues sequential fetches ahead of execution,
// buffers up to DEPTH {pc, inst} pairs and hands them to the core.
//   clk/resetn   : clock, async active-low reset
//   ibus         : instruction bus master
//   redir_valid  : one-cycle redirect, flushes queue, restarts at redir_pc
//   redir_pc     : redirect target (low two bits ignored)
//   f_valid/f_ready, f_inst, f_pc : queue head handshake and payload
//   f_level      : entries buffered
module vigna_prefetch import vigna_prefetch_pkg::*; #(
   parameter int                    DEPTH      = 2,
   parameter int                    ADDR_WIDTH = VIGNA_XLEN,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = ADDR_WIDTH'(VIGNA_CORE_RESET_ADDR)
) (
   input  logic                   clk,
   input  logic                   resetn,
   vigna_prefetch_if.master       ibus,
   input  logic                   redir_valid,
   input  logic [ADDR_WIDTH-1:0]  redir_pc,
   output logic                   f_valid,
   input  logic                   f_ready,
   output logic [VIGNA_ILEN-1:0]  f_inst,
   output logic [ADDR_WIDTH-1:0]  f_pc,
   output logic [$clog2(DEPTH):0] f_level
);
   localparam int            CW      = $clog2(DEPTH) + 1;
   localparam int            EW      = ADDR_WIDTH + VIGNA_ILEN;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic                  i_valid_q, i_valid_d;
   logic [ADDR_WIDTH-1:0] i_addr_q, i_addr_d;
   logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
   logic                  discard_q, discard_d;
   logic                  acc, push, pop;
   logic [CW-1:0]         count, count_nx;
   logic [EW-1:0]         fifo_dout;

   assign acc     = i_valid_q & ibus.i_ready;
   assign push    = acc & ~discard_q & ~redir_valid;
   assign pop     = f_valid & f_ready & ~redir_valid;
   assign f_valid = (count != '0);

   always_comb begin
      count_nx = count + CW'(push) - CW'(pop);
      if (redir_valid) count_nx = '0;

      // fpc tracks the address of the next word to land in the queue.
      fpc_d = fpc_q;
      if (push)        fpc_d = fpc_q + ADDR_WIDTH'(VIGNA_INST_BYTES);
      if (redir_valid) fpc_d = {redir_pc[ADDR_WIDTH-1:2], 2'b00};

      // Poison the outstanding request only if it survives this edge.
      discard_d = discard_q;
      if (acc) discard_d = 1'b0;
      if (redir_valid && i_valid_q && !ibus.i_ready) discard_d = 1'b1;

      // Hold the request until it completes; otherwise issue if the queue
      // will still have a free slot for the response.
      i_valid_d = i_valid_q;
      i_addr_d  = i_addr_q;
      if (!i_valid_q || ibus.i_ready) begin
         i_valid_d = (count_nx < DEPTH_C) && !discard_d;
         i_addr_d  = fpc_d;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         i_valid_q <= 1'b0;
         i_addr_q  <= RESET_ADDR;
         fpc_q     <= RESET_ADDR;
         discard_q <= 1'b0;
      end else begin
         i_valid_q <= i_valid_d;
         i_addr_q  <= i_addr_d;
         fpc_q     <= fpc_d;
         discard_q <= discard_d;
      end
   end

   vigna_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (push),
      .pop    (pop),
      .flush  (redir_valid),
      .din    ({i_addr_q, ibus.i_rdata}),
      .dout   (fifo_dout),
      .count  (count)
   );

   assign ibus.i_valid = i_valid_q;
   assign ibus.i_addr  = i_addr_q;
   assign f_pc         = fifo_dout[EW-1:VIGNA_ILEN];
   assign f_inst       = fifo_dout[VIGNA_ILEN-1:0];
   assign f_level      = count;
endmodule

// File: tb/tb_vigna_prefetch.sv
// Directed bench for vigna_prefetch: DEPTH=2, RESET_ADDR=0x100.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vigna_prefetch;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        redir_valid;
   logic [31:0] redir_pc;
   logic        f_valid, f_ready;
   logic [31:0] f_inst, f_pc;
   logic [1:0]  f_level;
   int          n_tests = 0;
   int          n_fail  = 0;

   vigna_prefetch_if #(.ADDR_WIDTH(32)) ibus ();

   vigna_prefetch #(.DEPTH(2), .ADDR_WIDTH(32), .RESET_ADDR(32'h100)) dut (
      .clk(clk), .resetn(resetn), .ibus(ibus),
      .redir_valid(redir_valid), .redir_pc(redir_pc),
      .f_valid(f_valid), .f_ready(f_ready), .f_inst(f_inst),
      .f_pc(f_pc), .f_level(f_level)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      chk("lvl_max", 64'(f_level <= 2'd2), 64'd1);
   endtask

   // Zero-wait slave response for the current request.
   task automatic serve();
      ibus.i_rdata = inst_of(ibus.i_addr);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
   endtask

   initial begin
      redir_valid = 1'b0; redir_pc = '0; f_ready = 1'b1;
      ibus.i_ready = 1'b0; ibus.i_rdata = '0;

      // Reset state
      @(negedge clk);
      chk("rst_ivalid", ibus.i_valid, 0);
      chk("rst_iaddr",  ibus.i_addr, 32'h100);
      chk("rst_fvalid", f_valid, 0);
      chk("rst_level",  f_level, 0);
      resetn = 1'b1;

      // Streaming: 1 instr/clk, f_pc one cycle behind i_addr
      ibus.i_ready = 1'b1; f_ready = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk($sformatf("str_iv%0d", k), ibus.i_valid, 1);
         chk($sformatf("str_ia%0d", k), ibus.i_addr, 32'h100 + 4*(k-1));
         if (k >= 2) begin
            chk($sformatf("str_fpc%0d", k), f_pc, 32'h100 + 4*(k-2));
            chk($sformatf("str_fin%0d", k), f_inst, inst_of(32'h100 + 4*(k-2)));
            chk($sformatf("str_lvl%0d", k), f_level, 1);
         end
         serve();
      end

      // Back-pressure: exactly two accepts then stall
      do_reset();
      f_ready = 1'b0; ibus.i_ready = 1'b1;
      tick(); serve();
      tick(); serve();
      tick(); serve();
      chk("bp_ivalid", ibus.i_valid, 0);
      chk("bp_level",  f_level, 2);
      chk("bp_fpc",    f_pc, 32'h100);
      tick(); serve();
      chk("bp_ivalid2", ibus.i_valid, 0);
      chk("bp_level2",  f_level, 2);
      f_ready = 1'b1;
      tick(); serve();
      f_ready = 1'b0;
      chk("bp_reissue", ibus.i_valid, 1);
      chk("bp_addr",    ibus.i_addr, 32'h108);
      chk("bp_level3",  f_level, 1);
      chk("bp_fpc2",    f_pc, 32'h104);
      tick(); serve();
      chk("bp_level4",  f_level, 2);
      chk("bp_ivalid3", ibus.i_valid, 0);

      // Three-cycle wait slave
      do_reset();
      f_ready = 1'b0; ibus.i_ready = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("ws_iv%0d", k), ibus.i_valid, 1);
         chk($sformatf("ws_ia%0d", k), ibus.i_addr, 32'h100);
         chk($sformatf("ws_fv%0d", k), f_valid, 0);
      end
      ibus.i_ready = 1'b1; ibus.i_rdata = 32'h0050_0093;
      tick();
      ibus.i_ready = 1'b0;
      chk("ws_fvalid", f_valid, 1);
      chk("ws_fpc",    f_pc, 32'h100);
      chk("ws_finst",  f_inst, 32'h0050_0093);
      chk("ws_next",   ibus.i_addr, 32'h104);

      // Redirect while 0x108 is in flight
      do_reset();
      f_ready = 1'b1; ibus.i_ready = 1'b1;
      tick(); serve();
      tick(); serve();
      tick();
      chk("rd_inflight", ibus.i_addr, 32'h108);
      ibus.i_ready = 1'b0; redir_valid = 1'b1; redir_pc = 32'h2000;
      tick();
      redir_valid = 1'b0;
      chk("rd_level0", f_level, 0);
      chk("rd_fv0",    f_valid, 0);
      chk("rd_hold",   ibus.i_addr, 32'h108);
      chk("rd_holdv",  ibus.i_valid, 1);
      tick();
      chk("rd_hold2",  ibus.i_addr, 32'h108);
      ibus.i_ready = 1'b1; serve();
      tick();
      chk("rd_drop",   f_valid, 0);
      chk("rd_new_iv", ibus.i_valid, 1);
      chk("rd_new_ia", ibus.i_addr, 32'h2000);
      serve();
      tick();
      chk("rd_fpc",    f_pc, 32'h2000);
      chk("rd_finst",  f_inst, inst_of(32'h2000));
      serve();

      // Redirect coinciding with accept and pop; unaligned target
      do_reset();
      f_ready = 1'b1; ibus.i_ready = 1'b1;
      tick(); serve();
      tick();
      chk("rc_pre_lvl", f_level, 1);
      serve();
      redir_valid = 1'b1; redir_pc = 32'h3002;
      tick();
      redir_valid = 1'b0;
      chk("rc_level",  f_level, 0);
      chk("rc_fv",     f_valid, 0);
      chk("rc_iv",     ibus.i_valid, 1);
      chk("rc_ia",     ibus.i_addr, 32'h3000);
      serve();
      tick();
      chk("rc_fpc",    f_pc, 32'h3000);
      chk("rc_finst",  f_inst, inst_of(32'h3000));
      chk("rc_lvl1",   f_level, 1);

      // Async reset mid wait-state
      do_reset();
      f_ready = 1'b0; ibus.i_ready = 1'b1;
      tick(); serve();
      tick();
      ibus.i_ready = 1'b0;
      chk("ar_pre_fv", f_valid, 1);
      chk("ar_pre_iv", ibus.i_valid, 1);
      #2 resetn = 1'b0;
      #1;
      chk("ar_iv",  ibus.i_valid, 0);
      chk("ar_fv",  f_valid, 0);
      chk("ar_lvl", f_level, 0);
      chk("ar_ia",  ibus.i_addr, 32'h100);
      @(negedge clk);
      resetn = 1'b1;
      ibus.i_ready = 1'b1; f_ready = 1'b1;
      tick();
      chk("ar_restart", ibus.i_addr, 32'h100);
      serve();
      tick();
      chk("ar_fpc", f_pc, 32'h100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
